data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Responder end of the MEM-stage data-memory request/done handshake. Stage_MEM initiates load/store
//  requests, and this block answers each one after a fixed, programmable wait, asserting stall_mem so the
//  pipeline holds. It owns the word-organised data RAM and exposes a combinational display read port
//  (disp_addr/disp_data) for board debug, mirroring the register file's display port.
// PARAMETERS
//  ADDR_BITS    10  word-address width; RAM holds 2**ADDR_BITS 32-bit words
//  WAIT_CYCLES  2   extra BUSY cycles before the access is performed (0..15)
// PORTS
//  clock        in   1   sole clock, rising edge
//  reset        in   1   synchronous, active-high
//  req_valid    in   1   MEM stage requests an access; held with fields stable until resp_done
//  req_we       in   1   1 = store, 0 = load
//  req_addr     in   32  byte address; word index = req_addr[ADDR_BITS+1:2]; [1:0] ignored
//  req_wdata    in   32  store data
//  req_be       in   4   store byte enables, be[i] -> bits [8i+7:8i]; ignored for loads
//  resp_done    out  1   one-cycle pulse: access complete, resp_rdata/resp_err valid this cycle
//  resp_rdata   out  32  load data (registered); 0 for stores and errors
//  resp_err     out  1   with resp_done: address out of range
//  stall_mem    out  1   req_valid & ~resp_done (combinational); holds IF/ID/EX/MEM pipeline registers
//  disp_addr    in   ADDR_BITS  debug word index
//  disp_data    out  32  RAM[disp_addr], combinational, pre-write value in the cycle of a write
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, resp_done=0, resp_rdata=0, resp_err=0. RAM contents are NOT cleared.
//  FSM (registered):
//   IDLE: at edge with req_valid=1, latch we/addr/wdata/be, cnt<=WAIT_CYCLES, go BUSY.
//   BUSY: at edge, if cnt!=0 then cnt<=cnt-1; else perform the access and go RESP:
//    range check: req_addr[31:ADDR_BITS+2]!=0 -> resp_err<=1, resp_rdata<=0, no RAM write.
//    load: resp_rdata<=RAM[idx]. store: write enabled bytes only, resp_rdata<=0; be=0000 is a legal no-op.
//   RESP: resp_done=1 for exactly this cycle; next edge -> IDLE, resp_err<=0. A new request is never
//    accepted in RESP, so the initiator must present the next request after the done cycle.
//  Latency: request sampled at edge N -> access at edge N+WAIT_CYCLES+1 -> resp_done high in the
//   following cycle. stall_mem is high for WAIT_CYCLES+2 cycles per request.
//  Back-to-back: minimum request period is WAIT_CYCLES+3 cycles.
//  Latched fields are used, not live inputs. If req_valid drops in BUSY (protocol violation), the access
//   still completes and resp_done still pulses.
//  Reset during BUSY/RESP: abort to IDLE the same edge; an uncommitted store never writes; no resp_done.
//  resp_rdata holds its last value in IDLE/BUSY; it is valid only while resp_done=1.
// TESTING (ADDR_BITS=10, WAIT_CYCLES=2 unless noted)
//  1 store 0xDEADBEEF @0x10 be=1111, then load @0x10 -> each resp_done exactly 4 edges after accept,
//    stall_mem high 4 cycles; load returns 0xDEADBEEF, resp_err=0.
//  2 store 0x0000AA00 @0x10 be=0010 over test 1 -> load @0x10 returns 0xDEADAAEF; disp_addr=4 shows the
//    same after the write edge and the old value during it.
//  3 load/store @0x00001000 -> resp_err=1 with resp_done, resp_rdata=0, RAM[0] unchanged.
//  4 store 0x12345678 @0x20, assert reset for 1 cycle in BUSY -> no resp_done, back to IDLE;
//    load @0x20 returns the prior value.
//  5 WAIT_CYCLES=0: loads @0x0,@0x4 issued back-to-back -> resp_done pulses 3 cycles apart,
//    stall_mem low only in the cycle between requests.
//  6 drop req_valid mid-BUSY on a store -> resp_done still pulses, write committed.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-memory responder for the MEM stage: fixed-latency load/store handshake
// over a word-organised RAM, with a combinational debug display port.
module data_mem_responder #(
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req_valid,
    input  logic                 req_we,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    input  logic [3:0]           req_be,
    output logic                 resp_done,
    output logic [31:0]          resp_rdata,
    output logic                 resp_err,
    output logic                 stall_mem,
    input  logic [ADDR_BITS-1:0] disp_addr,
    output logic [31:0]          disp_data
);

    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t               state;
    logic [3:0]           cnt;
    logic                 lat_we;
    logic [31:0]          lat_addr;
    logic [31:0]          lat_wdata;
    logic [3:0]           lat_be;
    logic [31:0]          mem [DEPTH];
    logic [ADDR_BITS-1:0] idx;
    logic                 out_of_range;
    logic                 commit;
    logic                 mem_we;

    assign idx          = lat_addr[ADDR_BITS+1:2];
    assign out_of_range = |lat_addr[31:ADDR_BITS+2];
    // A reset arriving on the commit edge must suppress the write.
    assign commit       = (state == BUSY) && (cnt == 4'd0) && !reset;
    assign mem_we       = commit && lat_we && !out_of_range;

    assign stall_mem = req_valid & ~resp_done;
    assign disp_data = mem[disp_addr];

    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (lat_be[i]) begin
                    mem[idx][8*i +: 8] <= lat_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            resp_done  <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_we    <= req_we;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        lat_be    <= req_be;
                        cnt       <= 4'(WAIT_CYCLES);
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state     <= RESP;
                        resp_done <= 1'b1;
                        if (out_of_range) begin
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'd0;
                        end else if (lat_we) begin
                            resp_rdata <= 32'd0;
                        end else begin
                            resp_rdata <= mem[idx];
                        end
                    end
                end
                RESP: begin
                    resp_done <= 1'b0;
                    resp_err  <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus
// randomized loads/stores against a word-array reference model.
module tb_data_mem_responder;

    localparam int W = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        resp_done, resp_err, stall_mem;
    logic [31:0] resp_rdata, disp_data;
    logic [9:0]  disp_addr;

    logic        z_req_valid, z_req_we;
    logic [31:0] z_req_addr, z_req_wdata;
    logic [3:0]  z_req_be;
    logic        z_resp_done, z_resp_err, z_stall_mem;
    logic [31:0] z_resp_rdata, z_disp_data;
    logic [9:0]  z_disp_addr;

    always #5 clock = ~clock;

    data_mem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(W)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_done(resp_done), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .stall_mem(stall_mem),
        .disp_addr(disp_addr), .disp_data(disp_data)
    );

    data_mem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(0)) dut0 (
        .clock(clock), .reset(reset),
        .req_valid(z_req_valid), .req_we(z_req_we),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be),
        .resp_done(z_resp_done), .resp_rdata(z_resp_rdata),
        .resp_err(z_resp_err), .stall_mem(z_stall_mem),
        .disp_addr(z_disp_addr), .disp_data(z_disp_data)
    );

    int          errors = 0;
    int          checks = 0;
    logic [31:0] ref_mem [16];
    logic [31:0] last_rdata, disp_pre, disp_post;
    logic        last_err;
    int          last_lat, last_stall;
    logic        drop_mid = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic access(input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be);
        int lat;
        int st;
        @(negedge clock);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        #1;
        st = stall_mem ? 1 : 0;
        lat = 0;
        disp_pre = 'x;
        disp_post = 'x;
        while (1) begin
            @(negedge clock);
            lat++;
            if (lat == W + 1) disp_pre = disp_data;
            if (lat == W + 2) disp_post = disp_data;
            if (resp_done || lat >= 20) break;
            if (stall_mem) st++;
            if (drop_mid && lat == 1) req_valid = 1'b0;
        end
        last_lat   = lat;
        last_stall = st;
        last_rdata = resp_rdata;
        last_err   = resp_err;
        req_valid  = 1'b0;
        @(negedge clock);
        chk("done_pulse_width", {31'd0, resp_done}, 32'd0);
    endtask

    task automatic op(input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be);
        logic        oor;
        logic [3:0]  w;
        logic [31:0] exp_rd;
        oor    = (addr >> 12) != 0;
        w      = addr[5:2];
        exp_rd = (oor || we) ? 32'd0 : ref_mem[w];
        access(we, addr, wdata, be);
        chk("latency", last_lat, W + 2);
        if (!drop_mid) chk("stall_cycles", last_stall, W + 2);
        chk("resp_err", {31'd0, last_err}, {31'd0, oor});
        chk("resp_rdata", last_rdata, exp_rd);
        if (!oor && we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) ref_mem[w][8*i +: 8] = wdata[8*i +: 8];
            end
        end
    endtask

    task automatic abort_store(input int k);
        int seen;
        @(negedge clock);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h12345678;
        req_be    = 4'hF;
        repeat (k) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        req_valid = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clock);
            if (resp_done) seen++;
        end
        chk("abort_no_done", seen, 0);
    endtask

    logic [31:0] r0, prior;
    logic        t_we [4];
    logic [31:0] t_addr [4];
    logic [31:0] t_data [4];
    int          done_t [4];
    logic [31:0] rd [4];
    int          n, cyc, stall_low;
    logic [31:0] ra;

    task automatic z_set(input int i);
        z_req_valid = 1'b1;
        z_req_we    = t_we[i];
        z_req_addr  = t_addr[i];
        z_req_wdata = t_data[i];
        z_req_be    = 4'hF;
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; req_be = '0; disp_addr = '0;
        z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = '0;
        z_req_wdata = '0; z_req_be = '0; z_disp_addr = '0;
        repeat (3) @(negedge clock);
        chk("rst_done", {31'd0, resp_done}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", {31'd0, resp_err}, 32'd0);
        chk("rst_stall", {31'd0, stall_mem}, 32'd0);
        reset = 1'b0;

        for (int w = 0; w < 16; w++) op(1'b1, 32'(w * 4), $urandom, 4'hF);

        op(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        op(1'b0, 32'h10, 32'h0, 4'h0);
        chk("t1_load", last_rdata, 32'hDEADBEEF);

        disp_addr = 10'd4;
        op(1'b1, 32'h10, 32'h0000AA00, 4'b0010);
        chk("t2_disp_pre", disp_pre, 32'hDEADBEEF);
        chk("t2_disp_post", disp_post, 32'hDEADAAEF);
        op(1'b0, 32'h13, 32'h0, 4'hF);
        chk("t2_load", last_rdata, 32'hDEADAAEF);

        r0 = ref_mem[0];
        op(1'b0, 32'h00001000, 32'h0, 4'hF);
        op(1'b1, 32'h00001000, 32'hFFFFFFFF, 4'hF);
        chk("t3_err", {31'd0, last_err}, 32'd1);
        op(1'b0, 32'h0, 32'h0, 4'h0);
        chk("t3_ram0", last_rdata, r0);

        op(1'b1, 32'h20, 32'h0BADF00D, 4'hF);
        prior = 32'h0BADF00D;
        abort_store(1);
        abort_store(W + 1);
        op(1'b0, 32'h20, 32'h0, 4'h0);
        chk("t4_prior", last_rdata, prior);

        drop_mid = 1'b1;
        op(1'b1, 32'h24, 32'hCAFEF00D, 4'hF);
        drop_mid = 1'b0;
        op(1'b0, 32'h24, 32'h0, 4'h0);
        chk("t6_commit", last_rdata, 32'hCAFEF00D);

        op(1'b0, 32'h0, 32'h0, 4'h0);
        op(1'b1, 32'h0, 32'h0, 4'h0);
        op(1'b0, 32'h0, 32'h0, 4'h0);
        chk("be0_noop", last_rdata, ref_mem[0]);

        repeat (40) begin
            if ($urandom_range(0, 7) == 0)
                ra = {20'($urandom_range(1, 20'hFFFFF)), 12'($urandom)};
            else
                ra = {26'd0, 4'($urandom), 2'($urandom)};
            op(1'($urandom), ra, $urandom, 4'($urandom));
        end

        t_we[0] = 1'b1; t_addr[0] = 32'h0; t_data[0] = 32'hA5A5_0001;
        t_we[1] = 1'b1; t_addr[1] = 32'h4; t_data[1] = 32'h5A5A_0002;
        t_we[2] = 1'b0; t_addr[2] = 32'h0; t_data[2] = 32'h0;
        t_we[3] = 1'b0; t_addr[3] = 32'h4; t_data[3] = 32'h0;
        n = 0; cyc = 0; stall_low = 0;
        @(negedge clock);
        z_set(0);
        while (n < 4 && cyc < 60) begin
            @(negedge clock);
            cyc++;
            if (!z_stall_mem) stall_low++;
            if (z_resp_done) begin
                done_t[n] = cyc;
                rd[n] = z_resp_rdata;
                n++;
                if (n < 4) z_set(n);
                else z_req_valid = 1'b0;
            end
        end
        chk("t5_count", n, 4);
        chk("t5_first", done_t[0], 2);
        for (int i = 1; i < 4; i++)
            chk("t5_period", done_t[i] - done_t[i-1], 3);
        chk("t5_stall_low", stall_low, 4);
        chk("t5_st0", rd[0], 32'd0);
        chk("t5_ld0", rd[2], 32'hA5A5_0001);
        chk("t5_ld4", rd[3], 32'h5A5A_0002);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
